// File: rtl/mem_bank_pkg.sv
// Shared types for the mem_bank RAM: clear-sweep FSM states and sweep pointer sizing.
// Used by mem_bank and mem_bank_clr_seq; optional parity is enabled with MEM_BANK_PARITY_EN.
package mem_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Bits needed to count rows 0..depth-1; a single-row bank still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_bank_clr_seq.sv
// Clear-sweep sequencer: walks every row once after reset or a clr pulse, one row per cycle.
// Outputs are registered; busy is high for exactly DEPTH cycles per sweep.
module mem_bank_clr_seq
    import mem_bank_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam int PW = ptr_w(DEPTH);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic            r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Reset restarts the sweep from row 0, even mid-sweep.
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clr) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_ptr == PW'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = AW'(r_ptr);

endmodule

// File: rtl/mem_bank.sv
// Single-port flop RAM bank with 1-cycle registered read, rvalid strobe, sweep clear and range guard.
// Optional per-row even parity with error injection when MEM_BANK_PARITY_EN is defined.
module mem_bank
    import mem_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cs,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_clr,
`ifdef MEM_BANK_PARITY_EN
    input  logic             i_perr_inj,
    output logic             o_perr,
`endif
    output logic [WIDTH-1:0] o_dout,
    output logic             o_rvalid,
    output logic             o_busy
);

`ifdef MEM_BANK_PARITY_EN
    localparam int RW = WIDTH + 1;
`else
    localparam int RW = WIDTH;
`endif
    localparam logic [AW:0] ROW_LIM = (AW + 1)'(DEPTH);

    logic [RW-1:0]    r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_dout;
    logic             r_rvalid;

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_in_range;
    logic             w_access;
    logic             w_host_wr;
    logic             w_host_rd;
    logic [RW-1:0]    w_wrow;
    logic [RW-1:0]    w_rrow;

    mem_bank_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // A clr pulse wins over a host access presented in the same cycle.
    assign w_in_range = ({1'b0, i_addr} < ROW_LIM);
    assign w_access   = i_cs & ~i_rst & ~w_busy & ~i_clr;
    assign w_host_wr  = w_access & i_we & w_in_range;
    assign w_host_rd  = w_access & ~i_we;
    assign w_rrow     = w_in_range ? r_mem[i_addr] : '0;

`ifdef MEM_BANK_PARITY_EN
    logic r_perr;
    logic w_rd_perr;

    assign w_wrow    = {(^i_din) ^ i_perr_inj, i_din};
    assign w_rd_perr = w_in_range & (w_rrow[WIDTH] ^ (^w_rrow[WIDTH-1:0]));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perr <= 1'b0;
        end else if (w_host_rd) begin
            r_perr <= w_rd_perr;
        end
    end

    assign o_perr = r_perr;
`else
    assign w_wrow = i_din;
`endif

    // Storage has no reset; the sweep engine is the only way rows return to zero.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_host_wr) begin
            r_mem[i_addr] <= w_wrow;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_host_rd;
            if (w_host_rd) begin
                r_dout <= w_rrow[WIDTH-1:0];
            end
        end
    end

    assign o_dout   = r_dout;
    assign o_rvalid = r_rvalid;
    assign o_busy   = w_busy;

endmodule
